// File: rtl/regfile_writeback_if.sv
// Result and write-port bundle for regfile_writeback: ALU and load
// valid/ready handshakes plus the register file write port.
interface regfile_writeback_if #(
    parameter int unsigned N = 32
);
    logic         alu_valid;
    logic         alu_ready;
    logic [4:0]   alu_rd;
    logic [N-1:0] alu_data;
    logic         ld_valid;
    logic         ld_ready;
    logic [4:0]   ld_rd;
    logic [N-1:0] ld_data;
    logic [4:0]   wb_addr;
    logic [N-1:0] wb_data;
    logic         wb_enable;

    modport master (
        output alu_valid, alu_rd, alu_data,
        input  alu_ready,
        output ld_valid, ld_rd, ld_data,
        input  ld_ready,
        input  wb_addr, wb_data, wb_enable
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        output alu_ready,
        input  ld_valid, ld_rd, ld_data,
        output ld_ready,
        output wb_addr, wb_data, wb_enable
    );
endinterface

// File: rtl/regfile_writeback.sv
// Register file write-port arbiter: load FIFO over ALU priority, registered
// write port, and a pending-write scoreboard for RAW hazard detection.
module regfile_writeback #(
    parameter int unsigned N        = 32,
    parameter int unsigned LQ_DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 issue_valid,
    input  logic [4:0]           issue_rd,
    regfile_writeback_if.slave   bus,
    input  logic [4:0]           rs1_addr,
    input  logic [4:0]           rs2_addr,
    output logic                 rs1_busy,
    output logic                 rs2_busy
);
    localparam int unsigned RW   = 5;
    localparam int unsigned NREG = 32;
    localparam int unsigned PW   = $clog2(LQ_DEPTH);
    localparam int unsigned CW   = $clog2(LQ_DEPTH + 1);

    logic [RW-1:0]   lq_rd   [LQ_DEPTH];
    logic [N-1:0]    lq_data [LQ_DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count;
    logic            lq_empty, lq_full, push, pop, alu_take;
    logic            sel_valid;
    logic [RW-1:0]   sel_rd;
    logic [N-1:0]    sel_data;
    logic [NREG-1:0] busy, busy_next;

    // Handshakes depend only on the registered FIFO occupancy.
    always_comb begin
        lq_empty = (count == '0);
        lq_full  = (count == CW'(LQ_DEPTH));
        push     = bus.ld_valid & ~lq_full;
        pop      = ~lq_empty;
        alu_take = bus.alu_valid & lq_empty;
    end

    assign bus.ld_ready  = ~lq_full;
    assign bus.alu_ready = lq_empty;

    // Fixed priority: buffered load first, then the ALU.
    always_comb begin
        sel_valid = 1'b0;
        sel_rd    = '0;
        sel_data  = '0;
        if (pop) begin
            sel_valid = 1'b1;
            sel_rd    = lq_rd[rd_ptr];
            sel_data  = lq_data[rd_ptr];
        end else if (alu_take) begin
            sel_valid = 1'b1;
            sel_rd    = bus.alu_rd;
            sel_data  = bus.alu_data;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            lq_rd[wr_ptr]   <= bus.ld_rd;
            lq_data[wr_ptr] <= bus.ld_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Newer issue wins over a same-cycle retirement of the same register.
    always_comb begin
        busy_next = busy;
        if (sel_valid && sel_rd != '0) busy_next[sel_rd] = 1'b0;
        if (issue_valid && issue_rd != '0) busy_next[issue_rd] = 1'b1;
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy          <= '0;
            bus.wb_enable <= 1'b0;
            bus.wb_addr   <= '0;
            bus.wb_data   <= '0;
        end else begin
            busy <= busy_next;
            if (sel_valid) begin
                bus.wb_enable <= (sel_rd != '0);
                bus.wb_addr   <= sel_rd;
                bus.wb_data   <= sel_data;
            end else begin
                bus.wb_enable <= 1'b0;
            end
        end
    end

    assign rs1_busy = busy[rs1_addr];
    assign rs2_busy = busy[rs2_addr];
endmodule

// File: tb/tb_regfile_writeback.sv
// Randomized self-checking bench for regfile_writeback against a queue-based
// reference model of the write-back rules.
module tb_regfile_writeback;
    localparam int unsigned N        = 32;
    localparam int unsigned LQ_DEPTH = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       issue_valid;
    logic [4:0] issue_rd;
    logic [4:0] rs1_addr, rs2_addr;
    logic       rs1_busy, rs2_busy;

    regfile_writeback_if #(.N(N)) bus ();

    regfile_writeback #(.N(N), .LQ_DEPTH(LQ_DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .bus         (bus.slave),
        .rs1_addr    (rs1_addr),
        .rs2_addr    (rs2_addr),
        .rs1_busy    (rs1_busy),
        .rs2_busy    (rs2_busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [4:0]   mq_rd[$];
    logic [N-1:0] mq_data[$];
    logic [31:0]  m_busy;
    logic         m_wb_en;
    logic [4:0]   m_wb_addr;
    logic [N-1:0] m_wb_data;

    // Reference model: applies one clock edge of the write-back rules, then waits for it.
    task automatic tick();
        logic         sel;
        logic [4:0]   srd;
        logic [N-1:0] sdat;
        bit           ld_ok;
        if (!rst_n) begin
            mq_rd.delete();
            mq_data.delete();
            m_busy    = '0;
            m_wb_en   = 1'b0;
            m_wb_addr = '0;
            m_wb_data = '0;
        end else begin
            ld_ok = (mq_rd.size() < LQ_DEPTH);
            sel   = 1'b0;
            srd   = '0;
            sdat  = '0;
            if (mq_rd.size() > 0) begin
                sel  = 1'b1;
                srd  = mq_rd.pop_front();
                sdat = mq_data.pop_front();
            end else if (bus.alu_valid) begin
                sel  = 1'b1;
                srd  = bus.alu_rd;
                sdat = bus.alu_data;
            end
            if (bus.ld_valid && ld_ok) begin
                mq_rd.push_back(bus.ld_rd);
                mq_data.push_back(bus.ld_data);
            end
            if (sel && srd != 0) m_busy[srd] = 1'b0;
            if (issue_valid && issue_rd != 0) m_busy[issue_rd] = 1'b1;
            if (sel) begin
                m_wb_en   = (srd != 0);
                m_wb_addr = srd;
                m_wb_data = sdat;
            end else begin
                m_wb_en = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        issue_valid   = 1'b0;
        issue_rd      = '0;
        bus.alu_valid = 1'b0;
        bus.alu_rd    = '0;
        bus.alu_data  = '0;
        bus.ld_valid  = 1'b0;
        bus.ld_rd     = '0;
        bus.ld_data   = '0;
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        idle_inputs();
        bus.alu_valid = 1'b1;
        bus.alu_rd    = 5'd3;
        bus.alu_data  = $urandom;
        bus.ld_valid  = 1'b1;
        bus.ld_rd     = 5'd4;
        bus.ld_data   = $urandom;
        rs1_addr      = 5'd3;
        rs2_addr      = 5'd4;
        tick();
        tick();
        n_cmp++; if (bus.wb_enable !== 1'b0) begin n_err++; $display("FAIL reset_wb_enable got %b exp 0", bus.wb_enable); end
        n_cmp++; if (bus.wb_addr !== 5'd0) begin n_err++; $display("FAIL reset_wb_addr got %0d exp 0", bus.wb_addr); end
        n_cmp++; if (bus.wb_data !== 32'd0) begin n_err++; $display("FAIL reset_wb_data got %h exp 0", bus.wb_data); end
        rst_n = 1'b1;
        idle_inputs();
        #1;
        n_cmp++; if (rs1_busy !== 1'b0 || rs2_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b%b exp 00", rs1_busy, rs2_busy); end
        n_cmp++; if (bus.ld_ready !== 1'b1) begin n_err++; $display("FAIL reset_ld_ready got %b exp 1", bus.ld_ready); end
        tick();
        n_cmp++; if (bus.wb_enable !== 1'b0) begin n_err++; $display("FAIL reset_no_write got %b exp 0", bus.wb_enable); end
    endtask

    task automatic test_alu_write();
        issue_valid = 1'b1;
        issue_rd    = 5'd5;
        tick();
        idle_inputs();
        bus.alu_valid = 1'b1;
        bus.alu_rd    = 5'd5;
        bus.alu_data  = 32'hDEADBEEF;
        rs1_addr      = 5'd5;
        #1;
        n_cmp++; if (bus.alu_ready !== 1'b1) begin n_err++; $display("FAIL alu_ready got %b exp 1", bus.alu_ready); end
        n_cmp++; if (rs1_busy !== 1'b1) begin n_err++; $display("FAIL alu_busy_before got %b exp 1", rs1_busy); end
        tick();
        idle_inputs();
        #1;
        n_cmp++; if (bus.wb_enable !== 1'b1 || bus.wb_addr !== 5'd5 || bus.wb_data !== 32'hDEADBEEF) begin
            n_err++; $display("FAIL alu_write got en=%b a=%0d d=%h exp en=1 a=5 d=deadbeef", bus.wb_enable, bus.wb_addr, bus.wb_data); end
        n_cmp++; if (rs1_busy !== 1'b0) begin n_err++; $display("FAIL alu_busy_after got %b exp 0", rs1_busy); end
    endtask

    task automatic test_load_priority();
        idle_inputs();
        bus.ld_valid  = 1'b1; bus.ld_rd  = 5'd7; bus.ld_data  = 32'h11;
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd8; bus.alu_data = 32'h22;
        #1;
        n_cmp++; if (bus.alu_ready !== 1'b1) begin n_err++; $display("FAIL prio_alu_ready_empty got %b exp 1", bus.alu_ready); end
        tick();
        idle_inputs();
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd10; bus.alu_data = 32'h33;
        #1;
        n_cmp++; if (bus.alu_ready !== 1'b0) begin n_err++; $display("FAIL prio_alu_ready_busy got %b exp 0", bus.alu_ready); end
        n_cmp++; if (bus.wb_enable !== 1'b1 || bus.wb_addr !== 5'd8 || bus.wb_data !== 32'h22) begin
            n_err++; $display("FAIL prio_first got en=%b a=%0d d=%h exp en=1 a=8 d=22", bus.wb_enable, bus.wb_addr, bus.wb_data); end
        tick();
        n_cmp++; if (bus.wb_enable !== 1'b1 || bus.wb_addr !== 5'd7 || bus.wb_data !== 32'h11) begin
            n_err++; $display("FAIL prio_load got en=%b a=%0d d=%h exp en=1 a=7 d=11", bus.wb_enable, bus.wb_addr, bus.wb_data); end
        n_cmp++; if (bus.alu_ready !== 1'b1) begin n_err++; $display("FAIL prio_alu_ready_drained got %b exp 1", bus.alu_ready); end
        tick();
        idle_inputs();
        #1;
        n_cmp++; if (bus.wb_enable !== 1'b1 || bus.wb_addr !== 5'd10 || bus.wb_data !== 32'h33) begin
            n_err++; $display("FAIL prio_alu_late got en=%b a=%0d d=%h exp en=1 a=10 d=33", bus.wb_enable, bus.wb_addr, bus.wb_data); end
        tick();
    endtask

    task automatic test_x0_drop();
        idle_inputs();
        issue_valid = 1'b1; issue_rd = 5'd12;
        tick();
        issue_valid = 1'b1; issue_rd = 5'd0;
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd0; bus.alu_data = 32'hFFFFFFFF;
        rs1_addr = 5'd12; rs2_addr = 5'd0;
        #1;
        n_cmp++; if (bus.alu_ready !== 1'b1) begin n_err++; $display("FAIL x0_alu_ready got %b exp 1", bus.alu_ready); end
        tick();
        idle_inputs();
        #1;
        n_cmp++; if (bus.wb_enable !== 1'b0) begin n_err++; $display("FAIL x0_wb_enable got %b exp 0", bus.wb_enable); end
        n_cmp++; if (rs1_busy !== 1'b1 || rs2_busy !== 1'b0) begin n_err++; $display("FAIL x0_busy got %b%b exp 10", rs1_busy, rs2_busy); end
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd12; bus.alu_data = $urandom;
        tick();
        idle_inputs();
    endtask

    task automatic test_collision();
        idle_inputs();
        issue_valid = 1'b1; issue_rd = 5'd9;
        tick();
        issue_valid = 1'b1; issue_rd = 5'd9;
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd9; bus.alu_data = 32'h0BADF00D;
        rs1_addr = 5'd9;
        tick();
        idle_inputs();
        #1;
        n_cmp++; if (bus.wb_enable !== 1'b1 || bus.wb_addr !== 5'd9) begin
            n_err++; $display("FAIL collide_write got en=%b a=%0d exp en=1 a=9", bus.wb_enable, bus.wb_addr); end
        n_cmp++; if (rs1_busy !== 1'b1) begin n_err++; $display("FAIL collide_busy got %b exp 1", rs1_busy); end
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd9; bus.alu_data = $urandom;
        tick();
        idle_inputs();
        #1;
        n_cmp++; if (rs1_busy !== 1'b0) begin n_err++; $display("FAIL collide_release got %b exp 0", rs1_busy); end
    endtask

    task automatic test_random();
        for (int cyc = 0; cyc < 600; cyc++) begin
            rst_n         = ($urandom_range(0, 63) != 0);
            issue_valid   = $urandom_range(0, 1);
            issue_rd      = 5'($urandom);
            bus.alu_valid = ($urandom_range(0, 3) != 0);
            bus.alu_rd    = 5'($urandom);
            bus.alu_data  = $urandom;
            bus.ld_valid  = $urandom_range(0, 1);
            bus.ld_rd     = 5'($urandom);
            bus.ld_data   = $urandom;
            rs1_addr      = 5'($urandom);
            rs2_addr      = 5'($urandom);
            #1;
            n_cmp++; if (bus.alu_ready !== (mq_rd.size() == 0)) begin
                n_err++; $display("FAIL rnd_alu_ready cyc=%0d got %b exp %b", cyc, bus.alu_ready, mq_rd.size() == 0); end
            n_cmp++; if (bus.ld_ready !== (mq_rd.size() < LQ_DEPTH)) begin
                n_err++; $display("FAIL rnd_ld_ready cyc=%0d got %b exp %b", cyc, bus.ld_ready, mq_rd.size() < LQ_DEPTH); end
            n_cmp++; if (rs1_busy !== m_busy[rs1_addr] || rs2_busy !== m_busy[rs2_addr]) begin
                n_err++; $display("FAIL rnd_busy cyc=%0d got %b%b exp %b%b", cyc, rs1_busy, rs2_busy, m_busy[rs1_addr], m_busy[rs2_addr]); end
            tick();
            n_cmp++; if (bus.wb_enable !== m_wb_en || bus.wb_addr !== m_wb_addr || bus.wb_data !== m_wb_data) begin
                n_err++; $display("FAIL rnd_wb cyc=%0d got en=%b a=%0d d=%h exp en=%b a=%0d d=%h",
                                  cyc, bus.wb_enable, bus.wb_addr, bus.wb_data, m_wb_en, m_wb_addr, m_wb_data); end
        end
        rst_n = 1'b1;
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        rst_n    = 1'b0;
        rs1_addr = '0;
        rs2_addr = '0;
        m_busy   = '0;
        @(posedge clk);
        #1;
        test_reset();
        test_alu_write();
        test_load_priority();
        test_x0_drop();
        test_collision();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
